// File: rtl/branch_predict_unit_if.sv
// ============================================================================
//  Module   : branch_predict_unit_if
//  Purpose  : Fetch-lookup, execute-resolve and redirect signals of the
//             branch predict unit, with pipeline (master) and unit (slave) views.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface branch_predict_unit_if;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;

  logic        r_valid;
  logic [3:0]  r_mode;
  logic [31:0] r_pc;
  logic [15:0] r_offset;
  logic [25:0] r_jump_addr;
  logic [31:0] r_jreg_addr;
  logic        r_zero;
  logic        r_neg;
  logic        r_pos;
  logic        r_pred_taken;
  logic [31:0] r_pred_target;

  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  modport master (
    output f_pc, r_valid, r_mode, r_pc, r_offset, r_jump_addr, r_jreg_addr,
           r_zero, r_neg, r_pos, r_pred_taken, r_pred_target,
    input  f_pred_taken, f_pred_target, redirect, redirect_pc,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  f_pc, r_valid, r_mode, r_pc, r_offset, r_jump_addr, r_jreg_addr,
           r_zero, r_neg, r_pos, r_pred_taken, r_pred_target,
    output f_pred_taken, f_pred_target, redirect, redirect_pc,
           stat_branches, stat_mispredicts
  );
endinterface

`default_nettype wire

// File: rtl/branch_predict_unit.sv
// ============================================================================
//  Module   : branch_predict_unit
//  Purpose  : Direct-mapped 2-bit branch predictor with target table; resolves
//             branches/jumps in execute and issues a registered redirect.
//             Optional statistics counters enabled by macro BRANCH_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module branch_predict_unit #(
  parameter int         ENTRIES  = 64,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input logic                 clk,
  input logic                 rst,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [3:0] c_mode_beq  = 4'h1;
  localparam logic [3:0] c_mode_bgez = 4'h2;
  localparam logic [3:0] c_mode_bgtz = 4'h3;
  localparam logic [3:0] c_mode_blez = 4'h4;
  localparam logic [3:0] c_mode_bltz = 4'h5;
  localparam logic [3:0] c_mode_bne  = 4'h6;
  localparam logic [3:0] c_mode_bc1t = 4'h7;
  localparam logic [3:0] c_mode_bc1f = 4'h8;
  localparam logic [3:0] c_mode_j    = 4'h9;
  localparam logic [3:0] c_mode_jr   = 4'hA;

  logic [1:0]         r_ctr [ENTRIES];
  logic [31:0]        r_tgt [ENTRIES];
  logic [ENTRIES-1:0] r_vld;
  logic               r_redirect;
  logic [31:0]        r_redirect_pc;

  logic [IDX_W-1:0]   w_fidx;
  logic [IDX_W-1:0]   w_ridx;
  logic               w_taken;
  logic               w_jump;
  logic               w_update;
  logic               w_mispredict;
  logic [31:0]        w_br_tgt;
  logic [31:0]        w_act_tgt;
  logic [31:0]        w_fix_pc;
  logic [1:0]         w_ctr_cur;
  logic [1:0]         w_ctr_nxt;
  logic               w_unused_bits;

  // Lookup reads the registered table, so a same-cycle update is not visible.
  assign w_fidx            = bus.f_pc[IDX_W+1:2];
  assign bus.f_pred_taken  = r_vld[w_fidx] & r_ctr[w_fidx][1];
  assign bus.f_pred_target = r_vld[w_fidx] ? r_tgt[w_fidx] : 32'd0;
  assign w_unused_bits     = ^{bus.f_pc[31:IDX_W+2], bus.f_pc[1:0]};

  assign w_ridx    = bus.r_pc[IDX_W+1:2];
  assign w_ctr_cur = r_ctr[w_ridx];
  assign w_br_tgt  = bus.r_pc + {{14{bus.r_offset[15]}}, bus.r_offset, 2'b00};

  always_comb begin
    w_taken = 1'b0;
    w_jump  = 1'b0;
    case (bus.r_mode)
      c_mode_beq:  w_taken = bus.r_zero & ~bus.r_neg & ~bus.r_pos;
      c_mode_bgez: w_taken = (bus.r_zero | bus.r_pos) & ~bus.r_neg;
      c_mode_bgtz: w_taken = bus.r_pos & ~bus.r_zero & ~bus.r_neg;
      c_mode_blez: w_taken = ~bus.r_pos & (bus.r_zero | bus.r_neg);
      c_mode_bltz: w_taken = bus.r_neg & ~bus.r_zero & ~bus.r_pos;
      c_mode_bne:  w_taken = (bus.r_pos | bus.r_neg) & ~bus.r_zero;
      c_mode_bc1t, c_mode_bc1f: w_taken = 1'b0;
      c_mode_j, c_mode_jr: begin
        w_taken = 1'b1;
        w_jump  = 1'b1;
      end
      default: w_taken = 1'b0;
    endcase
    w_taken  = w_taken & bus.r_valid;
    w_update = bus.r_valid & (bus.r_mode >= c_mode_beq) & (bus.r_mode <= c_mode_jr);
  end

  always_comb begin
    w_act_tgt = w_br_tgt;
    if (bus.r_mode == c_mode_j) begin
      w_act_tgt = {bus.r_pc[31:28], bus.r_jump_addr, 2'b00};
    end else if (bus.r_mode == c_mode_jr) begin
      w_act_tgt = bus.r_jreg_addr;
    end
  end

  assign w_mispredict = bus.r_valid &
                        ((w_taken != bus.r_pred_taken) |
                         (w_taken & bus.r_pred_taken & (w_act_tgt != bus.r_pred_target)));
  assign w_fix_pc     = w_taken ? w_act_tgt : (bus.r_pc + 32'd4);

  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    if (w_jump) begin
      w_ctr_nxt = 2'b11;
    end else if (w_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_INIT;
        r_tgt[i] <= 32'd0;
      end
      r_vld <= '0;
    end else if (w_update) begin
      r_ctr[w_ridx] <= w_ctr_nxt;
      // Not-taken outcomes keep the last known target for this slot.
      if (w_taken) begin
        r_vld[w_ridx] <= 1'b1;
        r_tgt[w_ridx] <= w_act_tgt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_redirect    <= 1'b0;
      r_redirect_pc <= 32'd0;
    end else begin
      r_redirect <= w_mispredict;
      if (w_mispredict) r_redirect_pc <= w_fix_pc;
    end
  end

  assign bus.redirect    = r_redirect;
  assign bus.redirect_pc = r_redirect_pc;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_br  <= 32'd0;
      r_stat_mis <= 32'd0;
    end else begin
      if (w_update)     r_stat_br  <= r_stat_br + 32'd1;
      if (w_mispredict) r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign bus.stat_branches    = r_stat_br;
  assign bus.stat_mispredicts = r_stat_mis;
`else
  assign bus.stat_branches    = 32'd0;
  assign bus.stat_mispredicts = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit: redirect expectations
// are queued when a resolve is driven and checked one clock later.
`default_nettype none

module tb_branch_predict_unit;

  localparam logic [3:0] M_NONE = 4'h0, M_BEQ = 4'h1, M_BGEZ = 4'h2, M_BGTZ = 4'h3,
                         M_BLEZ = 4'h4, M_BLTZ = 4'h5, M_BNE = 4'h6, M_J = 4'h9,
                         M_JR = 4'hA;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if bus ();

  branch_predict_unit #(.ENTRIES(64), .CTR_INIT(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rd;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_pc   = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic et,
                      input logic [31:0] etg);
    bus.f_pc = pc;
    #1;
    chk({tag, ".taken"}, 32'(bus.f_pred_taken), 32'(et));
    chk({tag, ".target"}, bus.f_pred_target, etg);
  endtask

  task automatic resolve(input logic [3:0] mode, input logic [31:0] pc,
                         input logic [15:0] off, input logic [25:0] ja,
                         input logic [31:0] jr, input logic z, input logic n,
                         input logic p, input logic pt, input logic [31:0] ptg,
                         input logic exp_rd, input logic [31:0] exp_rpc);
    bus.r_valid       = 1'b1;
    bus.r_mode        = mode;
    bus.r_pc          = pc;
    bus.r_offset      = off;
    bus.r_jump_addr   = ja;
    bus.r_jreg_addr   = jr;
    bus.r_zero        = z;
    bus.r_neg         = n;
    bus.r_pos         = p;
    bus.r_pred_taken  = pt;
    bus.r_pred_target = ptg;
    if (exp_rd) exp_pc = exp_rpc;
    sb.push_back('{exp_rd, exp_pc});
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    bus.r_valid = 1'b0;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=%0d expected=entry", tag, sb.size());
    end else begin
      e = sb.pop_front();
      chk({tag, ".redirect"}, 32'(bus.redirect), 32'(e.rd));
      chk({tag, ".redirect_pc"}, bus.redirect_pc, e.pc);
    end
  endtask

  task automatic idle(input string tag);
    sb.push_back('{1'b0, exp_pc});
    tick(tag);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.f_pc = 32'd0;        bus.r_valid = 1'b0;      bus.r_mode = M_NONE;
    bus.r_pc = 32'd0;        bus.r_offset = 16'd0;    bus.r_jump_addr = 26'd0;
    bus.r_jreg_addr = 32'd0; bus.r_zero = 1'b0;       bus.r_neg = 1'b0;
    bus.r_pos = 1'b0;        bus.r_pred_taken = 1'b0; bus.r_pred_target = 32'd0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.redirect", 32'(bus.redirect), 32'd0);
    chk("rst.redirect_pc", bus.redirect_pc, 32'd0);
    look("rst.lookup40", 32'h0000_0040, 1'b0, 32'd0);
    chk("rst.stat_br", bus.stat_branches, 32'd0);
    chk("rst.stat_mis", bus.stat_mispredicts, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // BEQ taken but predicted not-taken: one-cycle redirect, then learned.
    resolve(M_BEQ, 32'h100, 16'h0004, 26'd0, 32'd0, 1, 0, 0, 0, 32'd0, 1, 32'h110);
    look("beq.same_cycle", 32'h100, 1'b0, 32'd0);
    tick("beq");
    look("beq.after", 32'h100, 1'b1, 32'h110);
    idle("beq.pulse_end");

    // BNE backward, correctly predicted; drive counter into saturation.
    for (int k = 0; k < 3; k++) begin
      resolve(M_BNE, 32'h200, 16'hFFFE, 26'd0, 32'd0, 0, 0, 1, 1, 32'h1F8, 0, 32'd0);
      tick("bne.taken");
    end
    look("bne.tgt", 32'h200, 1'b1, 32'h1F8);
    resolve(M_BNE, 32'h200, 16'hFFFE, 26'd0, 32'd0, 1, 0, 0, 1, 32'h1F8, 1, 32'h204);
    tick("bne.nt1");
    look("bne.sat_hi", 32'h200, 1'b1, 32'h1F8);
    resolve(M_BNE, 32'h200, 16'hFFFE, 26'd0, 32'd0, 1, 0, 0, 1, 32'h1F8, 1, 32'h204);
    tick("bne.nt2");
    look("bne.weak", 32'h200, 1'b0, 32'h1F8);
    for (int k = 0; k < 2; k++) begin
      resolve(M_BNE, 32'h200, 16'hFFFE, 26'd0, 32'd0, 1, 0, 0, 0, 32'd0, 0, 32'd0);
      tick("bne.nt_low");
    end
    look("bne.sat_lo", 32'h200, 1'b0, 32'h1F8);

    // Jumps: J with wrong predicted target, JR predicted correctly.
    resolve(M_J, 32'h3000_0010, 16'd0, 26'h0000123, 32'd0, 0, 0, 0, 1, 32'd0, 1, 32'h3000_048C);
    tick("j");
    look("j.after", 32'h3000_0010, 1'b1, 32'h3000_048C);
    resolve(M_JR, 32'h400, 16'd0, 26'd0, 32'h1234_5678, 0, 0, 0, 1, 32'h1234_5678, 0, 32'd0);
    tick("jr");
    look("jr.after", 32'h400, 1'b1, 32'h1234_5678);
    resolve(M_NONE, 32'h400, 16'h0001, 26'd0, 32'd0, 0, 0, 1, 0, 32'd0, 0, 32'd0);
    tick("none");
    look("none.after", 32'h400, 1'b1, 32'h1234_5678);

    // BLTZ on zero is not taken; same-index lookup sees pre-update state.
    resolve(M_BLTZ, 32'h10, 16'h0008, 26'd0, 32'd0, 1, 0, 0, 1, 32'h30, 1, 32'h14);
    look("bltz.same_cycle", 32'h3000_0010, 1'b1, 32'h3000_048C);
    tick("bltz");

    resolve(M_BGEZ, 32'h80, 16'h0010, 26'd0, 32'd0, 0, 0, 1, 0, 32'd0, 1, 32'hC0);
    tick("bgez");
    look("bgez.after", 32'h80, 1'b1, 32'hC0);
    resolve(M_BGTZ, 32'h84, 16'h0010, 26'd0, 32'd0, 1, 0, 0, 0, 32'd0, 0, 32'd0);
    tick("bgtz");
    resolve(M_BLEZ, 32'h88, 16'hFFFF, 26'd0, 32'd0, 0, 1, 0, 0, 32'd0, 1, 32'h84);
    tick("blez");

    // Asynchronous reset while a redirect is being presented.
    resolve(M_BEQ, 32'h100, 16'h0004, 26'd0, 32'd0, 1, 0, 0, 0, 32'd0, 1, 32'h110);
    tick("prerst");
    rst = 1'b0;
    #1;
    chk("midrst.redirect", 32'(bus.redirect), 32'd0);
    chk("midrst.redirect_pc", bus.redirect_pc, 32'd0);
    look("midrst.lookup", 32'h3000_0010, 1'b0, 32'd0);
    chk("midrst.stat_br", bus.stat_branches, 32'd0);
    chk("midrst.stat_mis", bus.stat_mispredicts, 32'd0);
    exp_pc = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    resolve(M_BEQ, 32'h100, 16'h0004, 26'd0, 32'd0, 1, 0, 0, 0, 32'd0, 1, 32'h110);
    tick("post.beq_t");
    resolve(M_BEQ, 32'h104, 16'h0004, 26'd0, 32'd0, 0, 0, 1, 0, 32'd0, 0, 32'd0);
    tick("post.beq_nt");
`ifdef BRANCH_STATS_EN
    chk("post.stat_br", bus.stat_branches, 32'd2);
    chk("post.stat_mis", bus.stat_mispredicts, 32'd1);
`else
    chk("post.stat_br", bus.stat_branches, 32'd0);
    chk("post.stat_mis", bus.stat_mispredicts, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
